// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit (and later receive) blocks:
//   - tx_state_t     : frame state encoding (IDLE, START, D0..D7, PARITY, STOP)
//   - DEFAULT_CLOCKS_PER_BAUD : 868 clocks per serial bit
//   - FRAME_BITS     : 10 for plain 8N1, 11 when UART_TX_PARITY_EN is defined
//   - IDLE_LEVEL     : level of the serial line when nothing is being sent
//   - next_data_state: step from one data-bit state to the next
// Configuration macro: UART_TX_PARITY_EN (adds an even-parity bit).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        D0,
        D1,
        D2,
        D3,
        D4,
        D5,
        D6,
        D7,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic IDLE_LEVEL = 1'b1;

    // D7 has no data successor; the caller decides between PARITY and STOP.
    function automatic tx_state_t next_data_state(input tx_state_t s);
        case (s)
            D0:      return D1;
            D1:      return D2;
            D2:      return D3;
            D3:      return D4;
            D4:      return D5;
            D5:      return D6;
            D6:      return D7;
            default: return STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Down-counter that times one serial bit. Loading sets the count to
// clocks_per_baud-1; it then counts down to 0 and holds there.
// Ports:
//   i_clk           : system clock
//   i_reset         : synchronous, active-high reset (count -> 0)
//   load            : restart the bit timer
//   clocks_per_baud : clocks per serial bit (>= 2)
//   baud_done       : high while the count is 0 (last cycle of the bit)
//   count           : current count value
// ---------------------------------------------------------------------------
module uart_baud_counter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        load,
    input  logic [23:0] clocks_per_baud,
    output logic        baud_done,
    output logic [23:0] count
);

    // Saturates at 0 so the counter never wraps when left idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count <= 24'd0;
        end else if (load) begin
            count <= clocks_per_baud - 24'd1;
        end else if (count != 24'd0) begin
            count <= count - 24'd1;
        end
    end

    assign baud_done = (count == 24'd0);

endmodule

// File: rtl/uart_tx_8n1.sv
// ---------------------------------------------------------------------------
// uart_tx_8n1
// Serial byte transmitter: start bit, 8 data bits LSB first, optional even
// parity, stop bit. o_busy covers the whole frame; writes while busy are
// dropped.
// Parameters:
//   CLOCKS_PER_BAUD : clocks per serial bit, legal range 2..2^24-1
// Ports:
//   i_clk     : system clock
//   i_reset   : synchronous, active-high reset
//   i_wr      : write strobe, request to send i_data
//   i_data    : character to transmit
//   o_uart_tx : serial line, idles high
//   o_busy    : frame in progress
// Configuration macro: UART_TX_PARITY_EN (inserts a PARITY bit before STOP).
// ---------------------------------------------------------------------------
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_uart_tx,
    output logic       o_busy
);

    generate
        if (CLOCKS_PER_BAUD < 24'd2) begin : g_bad_clocks_per_baud
            $error("uart_tx_8n1: CLOCKS_PER_BAUD must be at least 2");
        end
    endgenerate

    tx_state_t   state;
    logic [7:0]  shift_reg;
    logic        baud_load;
    logic        baud_done;
    logic [23:0] baud_count;

`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    // The bit timer restarts on an accepted write and at every bit boundary
    // except the end of STOP, where the line goes idle.
    assign baud_load = (state == IDLE) ? i_wr : (baud_done && (state != STOP));

    uart_baud_counter u_baud_counter (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .load            (baud_load),
        .clocks_per_baud (CLOCKS_PER_BAUD),
        .baud_done       (baud_done),
        .count           (baud_count)
    );

    // Frame sequencer. o_uart_tx is registered and is updated on the same
    // edge the state changes, so the line level always matches the state.
    // The shift register always presents the next data bit in bit 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            o_uart_tx <= IDLE_LEVEL;
            o_busy    <= 1'b0;
            shift_reg <= 8'hFF;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_wr) begin
                        shift_reg <= i_data;
                        state     <= START;
                        o_busy    <= 1'b1;
                        o_uart_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^i_data;
`endif
                    end
                end
                START, D0, D1, D2, D3, D4, D5, D6: begin
                    if (baud_done) begin
                        state     <= (state == START) ? D0 : next_data_state(state);
                        o_uart_tx <= shift_reg[0];
                        shift_reg <= {1'b1, shift_reg[7:1]};
                    end
                end
                D7: begin
                    if (baud_done) begin
`ifdef UART_TX_PARITY_EN
                        state     <= PARITY;
                        o_uart_tx <= parity_bit;
`else
                        state     <= STOP;
                        o_uart_tx <= IDLE_LEVEL;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        state     <= STOP;
                        o_uart_tx <= IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                        o_uart_tx <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_busy    <= 1'b0;
                    o_uart_tx <= IDLE_LEVEL;
                end
            endcase
        end
    end

    localparam logic [23:0] COUNT_MAX = CLOCKS_PER_BAUD - 24'd1;

    a_busy_matches_state: assert property (@(posedge i_clk) disable iff (i_reset)
        o_busy == (state != IDLE));

    a_line_high_idle_stop: assert property (@(posedge i_clk) disable iff (i_reset)
        ((state == IDLE) || (state == STOP)) |-> (o_uart_tx == IDLE_LEVEL));

    a_count_in_range: assert property (@(posedge i_clk) disable iff (i_reset)
        baud_count <= COUNT_MAX);

endmodule

// File: tb/tb_uart_tx_8n1.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_8n1
// Directed and randomized bench for uart_tx_8n1 with CLOCKS_PER_BAUD = 4.
// The expected line waveform for a byte is built from the frame layout
// (start 0, data LSB first, optional even parity, stop 1), each bit held
// for CPB cycles. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_8n1;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic [7:0] data;
    logic       tx;
    logic       busy;

    int assertCount = 0;
    int failCount   = 0;

    logic captured[$];

    uart_tx_8n1 #(
        .CLOCKS_PER_BAUD (24'(CPB))
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr      (wr),
        .i_data    (data),
        .o_uart_tx (tx),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case a bounded loop is ever defeated.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Serial frame for a byte, bit 0 transmitted first.
    function automatic logic [10:0] expectedFrame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive inputs for one full clock cycle, ending on the next falling edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
        wr    = w;
        data  = d;
        reset = r;
        @(negedge clk);
    endtask

    // Called on the first falling edge after the accepting edge. Records the
    // line while busy, optionally pokes ignored writes, then checks the frame.
    task automatic captureFrame(input string tag, input logic [7:0] d,
                                input int glitchA, input int glitchB,
                                input logic holdWr);
        logic [10:0] frame;
        logic [7:0]  decoded;
        int          n;
        int          bad;
        frame = expectedFrame(d);
        captured.delete();
        n = 0;
        while (busy === 1'b1 && n < FRAME * CPB + 8) begin
            captured.push_back(tx);
            if (n == glitchA || n == glitchB) applyStimulus(1'b1, 8'hAA, 1'b0);
            else                              applyStimulus(holdWr, d, 1'b0);
            n++;
        end
        checkOutput({tag, "_busy_cycles"}, 32'(n), 32'(FRAME * CPB));
        bad = 0;
        for (int c = 0; c < captured.size(); c++) begin
            if (captured[c] !== frame[c / CPB]) bad++;
        end
        checkOutput({tag, "_waveform_errors"}, 32'(bad), 32'd0);
        for (int k = 0; k < 8; k++) begin
            decoded[k] = captured[(k + 1) * CPB + CPB / 2];
        end
        checkOutput({tag, "_decoded"}, {24'd0, decoded}, {24'd0, d});
        checkOutput({tag, "_after_busy_tx"}, {30'd0, busy, tx}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        int         bad;
        int         hi;

        $display("[TB] uart_tx_8n1 bench, CLOCKS_PER_BAUD=%0d, frame=%0d bits", CPB, FRAME);

        // Reset, then a quiet line.
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("reset_busy_tx", {30'd0, busy, tx}, 32'd1);
        bad = 0;
        repeat (20) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if ({busy, tx} !== 2'b01) bad++;
        end
        checkOutput("idle_20_cycles", 32'(bad), 32'd0);

        // Alternating pattern.
        applyStimulus(1'b1, 8'h55, 1'b0);
        captureFrame("frame_55", 8'h55, -1, -1, 1'b0);

        // Writes during the frame are ignored.
        applyStimulus(1'b1, 8'h30, 1'b0);
        captureFrame("frame_30_ignored", 8'h30, 5, 20, 1'b0);
        bad = 0;
        repeat (CPB * 3) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if ({busy, tx} !== 2'b01) bad++;
        end
        checkOutput("no_queued_write", 32'(bad), 32'd0);

        // Random bytes.
        repeat (4) begin
            b = 8'($urandom);
            applyStimulus(1'b1, b, 1'b0);
            captureFrame("frame_random", b, -1, -1, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0);
        end

        // Back-to-back with the write held high.
        applyStimulus(1'b1, 8'h78, 1'b0);
        captureFrame("b2b_first", 8'h78, -1, -1, 1'b1);
        hi = 0;
        while (tx === 1'b1 && hi < 20) begin
            applyStimulus(1'b1, 8'h78, 1'b0);
            hi++;
        end
        checkOutput("b2b_high_between_starts", 32'(hi + CPB), 32'(CPB + 1));
        captureFrame("b2b_second", 8'h78, -1, -1, 1'b0);

        // Reset in the middle of a frame.
        b = 8'($urandom);
        applyStimulus(1'b1, b, 1'b0);
        repeat (17) applyStimulus(1'b0, b, 1'b0);
        checkOutput("midframe_busy_before_reset", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, b, 1'b1);
        checkOutput("midframe_reset_busy_tx", {30'd0, busy, tx}, 32'd1);
        applyStimulus(1'b0, b, 1'b0);
        checkOutput("after_reset_idle", {30'd0, busy, tx}, 32'd1);
        b = 8'($urandom);
        applyStimulus(1'b1, b, 1'b0);
        captureFrame("frame_after_reset", b, -1, -1, 1'b0);

`ifdef UART_TX_PARITY_EN
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h07, 1'b0);
        captureFrame("parity_07", 8'h07, -1, -1, 1'b0);
        checkOutput("parity_bit_07", {31'd0, captured[9 * CPB + CPB / 2]}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0);
        captureFrame("parity_03", 8'h03, -1, -1, 1'b0);
        checkOutput("parity_bit_03", {31'd0, captured[9 * CPB + CPB / 2]}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
